// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared widths and one-hot decode helper for the decoder family
package decoder_pkg;

    localparam int unsigned DEC_IN_W      = 2;
    localparam int unsigned DEC_OUT_W     = 1 << DEC_IN_W;
    localparam int unsigned DEC_MAX_IN_W  = 6;
    localparam int unsigned DEC_MAX_OUT_W = 1 << DEC_MAX_IN_W;

    // Sized for the widest legal select; callers cast the result down to their own width.
    function automatic logic [DEC_MAX_OUT_W-1:0] onehot_decode(
        input logic [DEC_MAX_IN_W-1:0] sel,
        input logic                    en
    );
        onehot_decode = '0;
        if (en) begin
            onehot_decode[sel] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/decoder_2to4_core.sv
// rtl/decoder_2to4_core.sv - combinational enable/select to active-high one-hot
module decoder_2to4_core
    import decoder_pkg::*;
#(
    parameter int unsigned IN_W  = DEC_IN_W,
    parameter int unsigned OUT_W = 1 << IN_W
) (
    input  logic             en,
    input  logic [IN_W-1:0]  sel,
    output logic [OUT_W-1:0] onehot
);

    logic [DEC_MAX_IN_W-1:0] sel_ext;

    always_comb begin
        sel_ext = DEC_MAX_IN_W'(sel);
        onehot  = OUT_W'(onehot_decode(sel_ext, en));
    end

endmodule

// File: rtl/decoder_2to4.sv
// rtl/decoder_2to4.sv - registered 2-to-4 decoder with enable and selectable output polarity
module decoder_2to4
    import decoder_pkg::*;
#(
    parameter int unsigned IN_W           = DEC_IN_W,
    parameter bit          OUT_ACTIVE_LOW = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [IN_W-1:0]      in,
    output logic [(1<<IN_W)-1:0] out,
    output logic                 out_valid
);

    localparam int unsigned OUT_W = 1 << IN_W;
    localparam logic [OUT_W-1:0] POL_MASK = {OUT_W{OUT_ACTIVE_LOW}};

    logic [OUT_W-1:0] onehot;
    logic [OUT_W-1:0] out_d;
    logic [OUT_W-1:0] out_q;
    logic             valid_d;
    logic             valid_q;

    decoder_2to4_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .en     (en),
        .sel    (in),
        .onehot (onehot)
    );

    // The core already returns all-zero when disabled, so the polarity mask alone yields all-inactive.
    always_comb begin
        out_d   = onehot ^ POL_MASK;
        valid_d = en;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q   <= POL_MASK;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_decoder_2to4.sv
// tb/tb_decoder_2to4.sv - directed and soak bench for both output polarities of decoder_2to4
module tb_decoder_2to4;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] sel;
    logic [3:0] out_hi;
    logic       vld_hi;
    logic [3:0] out_lo;
    logic       vld_lo;

    int n_cmp;
    int n_bad;

    decoder_2to4 #(.IN_W(2), .OUT_ACTIVE_LOW(1'b0)) u_dut_hi (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in        (sel),
        .out       (out_hi),
        .out_valid (vld_hi)
    );

    decoder_2to4 #(.IN_W(2), .OUT_ACTIVE_LOW(1'b1)) u_dut_lo (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in        (sel),
        .out       (out_lo),
        .out_valid (vld_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, want %b", tag, obs, exp);
        end
    endtask

    // Apply inputs, clock once, then sample just after the edge.
    task automatic step(input logic r, input logic e, input logic [1:0] s);
        rst_n = r;
        en    = e;
        sel   = s;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_both(input string tag, input logic v, input logic [3:0] hi);
        check({tag, "_hi"}, {3'b0, vld_hi, out_hi}, {3'b0, v, hi});
        check({tag, "_lo"}, {3'b0, vld_lo, out_lo}, {3'b0, v, ~hi});
    endtask

    logic [3:0] sweep_exp [4];
    logic [3:0] m_hi;
    logic       m_v;
    logic       r_r;
    logic       r_e;
    logic [1:0] r_s;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        sel   = 2'b00;
        sweep_exp[0] = 4'b0001;
        sweep_exp[1] = 4'b0010;
        sweep_exp[2] = 4'b0100;
        sweep_exp[3] = 4'b1000;

        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 2'b11);
            expect_both("reset", 1'b0, 4'b0000);
        end
        step(1'b1, 1'b1, 2'b11);
        expect_both("release", 1'b1, 4'b1000);

        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 2'(i));
            expect_both("en_off", 1'b0, 4'b0000);
        end

        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 2'(i));
            expect_both("en_on", 1'b1, sweep_exp[i]);
        end

        step(1'b1, 1'b1, 2'b10);
        expect_both("tog1", 1'b1, 4'b0100);
        step(1'b1, 1'b0, 2'b10);
        expect_both("tog0", 1'b0, 4'b0000);
        step(1'b1, 1'b1, 2'b10);
        expect_both("tog1b", 1'b1, 4'b0100);

        step(1'b1, 1'b1, 2'b01);
        check("alow_sel1", {4'b0, out_lo}, 8'b0000_1101);

        step(1'b1, 1'b0, 2'bxx);
        expect_both("x_in_dis", 1'b0, 4'b0000);

        step(1'b0, 1'b1, 2'b01);
        check("alow_reset", {4'b0, out_lo}, 8'b0000_1111);

        for (int i = 0; i < 1000; i++) begin
            r_r = ($urandom_range(0, 9) != 0);
            r_e = 1'($urandom_range(0, 1));
            r_s = 2'($urandom_range(0, 3));
            step(r_r, r_e, r_s);
            m_v  = r_r & r_e;
            m_hi = m_v ? (4'b0001 << r_s) : 4'b0000;
            expect_both("soak", m_v, m_hi);
            check("inv_hi", {7'b0, vld_hi ? $onehot(out_hi) : (out_hi == 4'b0000)}, 8'd1);
            check("inv_lo", {7'b0, vld_lo ? $onehot(~out_lo) : (out_lo == 4'b1111)}, 8'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
